pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the front end of the 5-stage core.
- Drives the PC write-enable, and the IF/ID pipeline register's write-enable and flush (load instruction=0, PC=0).
- Drives the ID/EX bubble insert.
- Resolves, with fixed priority, four conditions: data-cache stalls, taken branches, load-use hazards and instruction-cache misses.
- Counts stall and flush cycles for performance monitoring.

Parameters:
- CNT_W, 32, width of the stall_count and flush_count performance counters.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; 0 = reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_branch_taken  in  1  EX resolves a taken branch/jump; the target is valid this cycle.
- dcache_busy  in  1  MEM stage cannot complete; the whole pipe must freeze.
- icache_miss  in  1  fetch this cycle missed.
- icache_ready  in  1  miss fill complete; the instruction is valid this cycle.
- pc_write  out  1  PC register loads its next value.
- ifid_write  out  1  IF/ID loads new instruction/PC (ignored when ifid_flush=1).
- ifid_flush  out  1  IF/ID loads 0 (NOP); overrides ifid_write.
- idex_bubble  out  1  ID/EX loads a NOP instead of the ID instruction.
- busy_state  out  2  current state: 0=RUN, 1=IC_WAIT, 2=MEM_WAIT.
- stall_count  out  CNT_W  cycles with pc_write=0, saturating.
- flush_count  out  CNT_W  cycles with ifid_flush=1 caused by a taken branch, saturating.

Behaviour:
- Outputs are combinational from state and inputs (Mealy); state, redirect_pending and counters are registered.
- Load-use hazard (LU): ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Default outputs: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- While reset=0:
  - pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
  - Next state RUN; redirect_pending=0; both counters=0.
  - Reset overrides every state, including mid-miss and mid-freeze.
- RUN, evaluated in priority order:
  1. dcache_busy: all enables 0, no bubble, no flush; ex_branch_taken is ignored. Next state MEM_WAIT.
  2. ex_branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1. Stay in RUN. LU and icache_miss are ignored (wrong path).
  3. LU: pc_write=0, ifid_write=0, idex_bubble=1. Lasts exactly one cycle, because the load leaves EX. icache_miss is deferred (fetch repeats).
  4. icache_miss: pc_write=0, ifid_flush=1. Next state IC_WAIT.
- MEM_WAIT:
  - While dcache_busy: all enables 0.
  - First cycle dcache_busy=0: evaluate exactly as in RUN, with next state chosen by those rules.
- IC_WAIT:
  - Default: pc_write=0, ifid_flush=1.
  - dcache_busy: freeze (ifid_flush=0, ifid_write=0). Stay in IC_WAIT; the miss continues.
  - ex_branch_taken (not frozen): pc_write=1, idex_bubble=1, set redirect_pending. PC now holds the target; the in-flight fill is wrong-path.
  - LU (not frozen, no branch): ifid_flush=0, ifid_write=0, idex_bubble=1.
  - icache_ready & !redirect_pending: pc_write=1, ifid_write=1, ifid_flush=0. Next state RUN.
  - icache_ready & redirect_pending: pc_write=0, ifid_flush=1, clear redirect_pending. Next state RUN, which refetches at the target.
  - icache_ready together with ex_branch_taken: the branch wins. pc_write=1, ifid_flush=1, idex_bubble=1, next state RUN, the fill is discarded.
- Counters:
  - Increment on the qualifying cycle when reset=1.
  - Saturate at all-ones; no wrap.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs. Required: pc_write=0, ifid_flush=1, idex_bubble=1, busy_state=0, counters 0. On the release cycle with no events, pc_write=1 and ifid_write=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1. Required: one cycle with pc_write=0, ifid_write=0, idex_bubble=1, stall_count=1. With ex_rd=0: no stall.
- Branch over hazard: a cycle with both LU and ex_branch_taken=1. Required: pc_write=1, ifid_flush=1, idex_bubble=1, flush_count=1, stall_count unchanged.
- Icache miss: icache_miss=1, then icache_ready=1 four cycles later. Required: busy_state=1 for those 4 cycles with pc_write=0 and ifid_flush=1. On the ready cycle, ifid_write=1 and pc_write=1. Then RUN, stall_count=5.
- Redirect during miss: miss, branch taken on cycle 2, ready on cycle 4. Required: pc_write=1 on cycle 2; ifid_flush=1 and pc_write=0 on the ready cycle; RUN the next cycle.
- Dcache freeze plus mid-run reset: dcache_busy=1 for 3 cycles while ex_branch_taken=1. Required: no flush, busy_state=2, all enables 0. Then reset=0 during IC_WAIT. Required: RUN next cycle, counters 0, redirect_pending cleared.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the front end of the 5-stage core. It
// resolves, in fixed priority, data-cache freezes, taken branches, load-use
// hazards and instruction-cache misses. It also keeps saturating counters of
// stall and branch-flush cycles for performance monitoring.
//
// Ports:
//   clk             core clock, all state updates on the rising edge
//   reset           synchronous, active-low (0 = reset)
//   id_rs1/id_rs2   source register fields of the instruction in ID
//   id_uses_rs1/2   ID instruction actually reads rs1/rs2
//   ex_mem_read     EX instruction is a load
//   ex_rd           destination register of the EX instruction
//   ex_branch_taken EX resolves a taken branch/jump (target valid this cycle)
//   dcache_busy     MEM cannot complete; the whole pipe freezes
//   icache_miss     fetch this cycle missed
//   icache_ready    miss fill complete, instruction valid this cycle
//   pc_write        PC loads its next value
//   ifid_write      IF/ID loads new instruction/PC (ignored when flushing)
//   ifid_flush      IF/ID loads a NOP, overrides ifid_write
//   idex_bubble     ID/EX loads a NOP instead of the ID instruction
//   busy_state      0 = RUN, 1 = IC_WAIT, 2 = MEM_WAIT
//   stall_count     saturating count of cycles with pc_write = 0
//   flush_count     saturating count of branch-caused IF/ID flush cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             dcache_busy,
    input  logic             icache_miss,
    input  logic             icache_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       busy_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_IC_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             redirect_pending_reg;
    logic             redirect_pending_next;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] flush_count_reg;

    // ------------------------------------------------------------------
    // Load-use detection: one comparator per ID source operand.
    // ------------------------------------------------------------------
    logic [4:0] src_reg [2];
    logic [1:0] src_used;
    logic [1:0] src_match;
    logic       load_use;

    assign src_reg[0] = id_rs1;
    assign src_reg[1] = id_rs2;
    assign src_used   = {id_uses_rs2, id_uses_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = src_used[gi] && (src_reg[gi] == ex_rd);
        end
    endgenerate

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (|src_match);

    // ------------------------------------------------------------------
    // Next state and Mealy outputs
    // ------------------------------------------------------------------
    always_comb begin
        pc_write              = 1'b1;
        ifid_write            = 1'b1;
        ifid_flush            = 1'b0;
        idex_bubble           = 1'b0;
        state_next            = state_reg;
        redirect_pending_next = redirect_pending_reg;

        if (!reset) begin
            pc_write              = 1'b0;
            ifid_write            = 1'b0;
            ifid_flush            = 1'b1;
            idex_bubble           = 1'b1;
            state_next            = ST_RUN;
            redirect_pending_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IC_WAIT: begin
                    // Fetch is stalled and IF/ID holds a NOP while the fill runs.
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    if (dcache_busy) begin
                        ifid_flush = 1'b0;
                        ifid_write = 1'b0;
                    end else if (ex_branch_taken) begin
                        pc_write    = 1'b1;
                        idex_bubble = 1'b1;
                        if (icache_ready) begin
                            // Fill lands together with the redirect: drop it.
                            state_next            = ST_RUN;
                            redirect_pending_next = 1'b0;
                        end else begin
                            // PC now points at the target; the pending fill
                            // belongs to the wrong path.
                            redirect_pending_next = 1'b1;
                        end
                    end else if (load_use) begin
                        ifid_flush  = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (icache_ready) begin
                        if (!redirect_pending_reg) begin
                            pc_write   = 1'b1;
                            ifid_write = 1'b1;
                            ifid_flush = 1'b0;
                        end
                        // With a redirect pending the fill is discarded and
                        // RUN refetches from the target already in the PC.
                        state_next            = ST_RUN;
                        redirect_pending_next = 1'b0;
                    end
                end

                default: begin
                    // RUN, and MEM_WAIT once the data cache has released:
                    // both apply the same prioritised rules.
                    if (dcache_busy) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        state_next = ST_MEM_WAIT;
                    end else if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_next  = ST_RUN;
                    end else if (load_use) begin
                        // The load leaves EX next cycle, so one bubble
                        // clears it; a concurrent miss repeats on refetch.
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_next  = ST_RUN;
                    end else if (icache_miss) begin
                        pc_write   = 1'b0;
                        ifid_flush = 1'b1;
                        state_next = ST_IC_WAIT;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, redirect flag and performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        state_reg            <= state_next;
        redirect_pending_reg <= redirect_pending_next;
        if (!reset) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (!pc_write && !(&stall_count_reg)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
            if (ifid_flush && ex_branch_taken && !(&flush_count_reg)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign busy_state  = state_reg;
    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed scenarios with hand-computed expectations, followed by a biased
// random phase. A behavioural model tracks the controller mode, the redirect
// flag and the counters, and a single compare process checks every DUT output
// against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             dcache_busy;
    logic             icache_miss;
    logic             icache_ready;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       busy_state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .dcache_busy     (dcache_busy),
        .icache_miss     (icache_miss),
        .icache_ready    (icache_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .busy_state      (busy_state),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: mode 0 normal, 1 waiting on fetch fill,
    // 2 frozen by the data cache.
    // ------------------------------------------------------------------
    int mode      = 0;
    bit redirect  = 1'b0;
    bit known     = 1'b0;
    int m_stall   = 0;
    int m_flush   = 0;

    always @(negedge clk) begin
        bit hazard;
        bit e_pw, e_iw, e_fl, e_bb;
        int n_mode;
        bit n_redirect;

        hazard = ex_mem_read && (ex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        e_pw = 1; e_iw = 1; e_fl = 0; e_bb = 0;
        n_mode = mode;
        n_redirect = redirect;

        if (!reset) begin
            e_pw = 0; e_iw = 0; e_fl = 1; e_bb = 1;
            n_mode = 0; n_redirect = 0;
        end else if (mode == 1) begin
            e_pw = 0; e_fl = 1;
            if (dcache_busy) begin
                e_fl = 0; e_iw = 0;
            end else if (ex_branch_taken) begin
                e_pw = 1; e_bb = 1;
                if (icache_ready) begin
                    n_mode = 0; n_redirect = 0;
                end else begin
                    n_redirect = 1;
                end
            end else if (hazard) begin
                e_fl = 0; e_iw = 0; e_bb = 1;
            end else if (icache_ready) begin
                if (!redirect) begin
                    e_pw = 1; e_iw = 1; e_fl = 0;
                end
                n_mode = 0; n_redirect = 0;
            end
        end else begin
            if (dcache_busy) begin
                e_pw = 0; e_iw = 0; n_mode = 2;
            end else if (ex_branch_taken) begin
                e_fl = 1; e_bb = 1; n_mode = 0;
            end else if (hazard) begin
                e_pw = 0; e_iw = 0; e_bb = 1; n_mode = 0;
            end else if (icache_miss) begin
                e_pw = 0; e_fl = 1; n_mode = 1;
            end else begin
                n_mode = 0;
            end
        end

        check("pc_write", pc_write, e_pw);
        check("ifid_flush", ifid_flush, e_fl);
        check("idex_bubble", idex_bubble, e_bb);
        // ifid_write is a don't-care whenever IF/ID is being flushed, except
        // under reset where it must be held low.
        if (!e_fl || !reset) check("ifid_write", ifid_write, e_iw);
        if (known) begin
            check("busy_state", busy_state, mode);
            check("stall_count", stall_count, m_stall);
            check("flush_count", flush_count, m_flush);
        end

        if (!reset) begin
            m_stall = 0;
            m_flush = 0;
            known   = 1'b1;
        end else begin
            if (!e_pw && m_stall < CNT_MAX) m_stall++;
            if (e_fl && ex_branch_taken && m_flush < CNT_MAX) m_flush++;
        end
        mode     = n_mode;
        redirect = n_redirect;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 ns after the rising edge, literal
    // checks run 1 ns after the falling edge.
    // ------------------------------------------------------------------
    task automatic apply_raw(input bit rst_n, input bit br, input bit dc, input bit im,
                             input bit ir, input bit mr, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2,
                             input bit u1, input bit u2);
        @(posedge clk);
        #1;
        reset = rst_n; ex_branch_taken = br; dcache_busy = dc;
        icache_miss = im; icache_ready = ir; ex_mem_read = mr; ex_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        @(negedge clk);
        #1;
        $display("cyc rst_n=%0b br=%0b dc=%0b im=%0b ir=%0b mr=%0b rd=%0d rs1=%0d rs2=%0d -> pw=%0b iw=%0b fl=%0b bb=%0b st=%0d sc=%0d fc=%0d",
                 rst_n, br, dc, im, ir, mr, rd, rs1, rs2,
                 pc_write, ifid_write, ifid_flush, idex_bubble, busy_state, stall_count, flush_count);
    endtask

    // lu=1 builds a load-use on rs2; otherwise registers match but no load.
    task automatic apply(input bit lu, input bit br, input bit dc, input bit im, input bit ir);
        if (lu) apply_raw(1, br, dc, im, ir, 1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b1);
        else    apply_raw(1, br, dc, im, ir, 0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
    endtask

    task automatic apply_random(input bit rst_n);
        apply_raw(rst_n, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            apply_random(1'b0);
            check("rst pc_write", pc_write, 0);
            check("rst ifid_flush", ifid_flush, 1);
            check("rst idex_bubble", idex_bubble, 1);
            if (i > 0) begin
                check("rst busy_state", busy_state, 0);
                check("rst stall_count", stall_count, 0);
                check("rst flush_count", flush_count, 0);
            end
        end
    endtask

    task automatic do_reset();
        hold_reset(3);
        apply(0, 0, 0, 0, 0);
        check("rel pc_write", pc_write, 1);
        check("rel ifid_write", ifid_write, 1);
        check("rel busy_state", busy_state, 0);
        check("rel stall_count", stall_count, 0);
    endtask

    initial begin
        reset = 1'b0; ex_branch_taken = 0; dcache_busy = 0; icache_miss = 0;
        icache_ready = 0; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;

        // Reset and load-use
        do_reset();
        apply(1, 0, 0, 0, 0);
        check("lu pc_write", pc_write, 0);
        check("lu ifid_write", ifid_write, 0);
        check("lu idex_bubble", idex_bubble, 1);
        apply(0, 0, 0, 0, 0);
        check("lu once pc_write", pc_write, 1);
        check("lu stall_count", stall_count, 1);
        apply_raw(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        check("x0 pc_write", pc_write, 1);
        check("x0 idex_bubble", idex_bubble, 0);

        // Branch beats a load-use hazard
        apply(1, 1, 0, 0, 0);
        check("brlu pc_write", pc_write, 1);
        check("brlu ifid_flush", ifid_flush, 1);
        check("brlu idex_bubble", idex_bubble, 1);
        apply(0, 0, 0, 0, 0);
        check("brlu flush_count", flush_count, 1);
        check("brlu stall_count", stall_count, 1);

        // Icache miss with fill after four waiting cycles
        do_reset();
        apply(0, 0, 0, 1, 0);
        check("miss pc_write", pc_write, 0);
        check("miss ifid_flush", ifid_flush, 1);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 0);
            check("icw busy_state", busy_state, 1);
            check("icw pc_write", pc_write, 0);
            check("icw ifid_flush", ifid_flush, 1);
        end
        apply(0, 0, 0, 0, 1);
        check("rdy pc_write", pc_write, 1);
        check("rdy ifid_write", ifid_write, 1);
        check("rdy ifid_flush", ifid_flush, 0);
        apply(0, 0, 0, 0, 0);
        check("miss end busy_state", busy_state, 0);
        check("miss stall_count", stall_count, 5);

        // Redirect during a miss
        do_reset();
        apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0);
        check("redir pc_write", pc_write, 1);
        check("redir idex_bubble", idex_bubble, 1);
        apply(0, 0, 0, 0, 0);
        check("redir wait pc_write", pc_write, 0);
        apply(0, 0, 0, 0, 1);
        check("redir rdy ifid_flush", ifid_flush, 1);
        check("redir rdy pc_write", pc_write, 0);
        apply(0, 0, 0, 0, 0);
        check("redir end busy_state", busy_state, 0);
        check("redir stall_count", stall_count, 4);
        check("redir flush_count", flush_count, 1);

        // Branch arriving together with the fill
        apply(0, 0, 0, 1, 0);
        apply(0, 1, 0, 0, 1);
        check("brrdy pc_write", pc_write, 1);
        check("brrdy ifid_flush", ifid_flush, 1);
        apply(0, 0, 0, 0, 0);
        check("brrdy busy_state", busy_state, 0);

        // Dcache freeze ignores the branch, then reset in IC_WAIT
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 1, 0, 0);
            check("frz pc_write", pc_write, 0);
            check("frz ifid_write", ifid_write, 0);
            check("frz ifid_flush", ifid_flush, 0);
            check("frz idex_bubble", idex_bubble, 0);
            if (i > 0) check("frz busy_state", busy_state, 2);
        end
        apply(0, 0, 0, 0, 0);
        check("unfrz busy_state", busy_state, 2);
        check("unfrz pc_write", pc_write, 1);
        check("frz flush_count", flush_count, 0);
        apply(0, 0, 0, 1, 0);
        apply(0, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0);
        check("icfrz ifid_flush", ifid_flush, 0);
        check("icfrz busy_state", busy_state, 1);
        apply(1, 0, 0, 0, 0);
        check("iclu ifid_write", ifid_write, 0);
        check("iclu idex_bubble", idex_bubble, 1);
        hold_reset(1);
        apply(0, 0, 0, 0, 0);
        check("mrst busy_state", busy_state, 0);
        check("mrst stall_count", stall_count, 0);
        check("mrst flush_count", flush_count, 0);
        apply(0, 0, 0, 1, 0);
        apply(0, 0, 0, 0, 1);
        check("mrst rdy pc_write", pc_write, 1);
        check("mrst rdy ifid_flush", ifid_flush, 0);

        // Counter saturation
        do_reset();
        apply(0, 0, 0, 1, 0);
        for (int i = 0; i < 20; i++) apply(0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) apply(0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0);
        check("sat stall_count", stall_count, CNT_MAX);
        check("sat flush_count", flush_count, CNT_MAX);

        // Biased random traffic, occasional reset
        for (int i = 0; i < 400; i++) apply_random($urandom_range(0, 39) != 0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
